// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle RV32I core
// Optional ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP instead of acting as NOP.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_src,
   output logic [2:0] result_src,
   output logic       mem_timeout,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
      S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_ALUWB   = 4'd7,
      S_EXECI    = 4'd8,  S_JAL    = 4'd9,  S_BEQ    = 4'd10, S_JALR    = 4'd11,
      S_LUI      = 4'd12, S_AUIPC  = 4'd13, S_TRAP   = 4'd14
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = MEM_TIMEOUT[7:0];

   state_t     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       in_mem_state;
   logic       abort;
   logic       unused_inputs;

   // funct7_5 and funct3[2:1] are consumed by the ALU decoder, not here
   assign unused_inputs = ^{funct7_5, funct3[2:1]};

   always_comb begin
      in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
      abort        = (MEM_TIMEOUT != 0) && in_mem_state && (wait_cnt_q == TIMEOUT_LIM);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (abort) state_d = S_FETCH; else if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               7'h03, 7'h23: state_d = S_MEMADR;
               7'h33:        state_d = S_EXECR;
               7'h13:        state_d = S_EXECI;
               7'h6F:        state_d = S_JAL;
               7'h63:        state_d = S_BEQ;
               7'h67:        state_d = S_JALR;
               7'h37:        state_d = S_LUI;
               7'h17:        state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (opcode == 7'h23) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (abort) state_d = S_FETCH; else if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (abort || mem_ready) state_d = S_FETCH;
         S_EXECR, S_EXECI, S_JAL, S_AUIPC: state_d = S_ALUWB;
         S_JALR:     state_d = S_JAL;
         S_MEMWB, S_ALUWB, S_BEQ, S_LUI: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_FETCH;
      endcase

      // An abort restarts the count even when FETCH times out back into FETCH
      if ((state_d != state_q) || abort)
         wait_cnt_d = 8'd0;
      else if (in_mem_state && !mem_ready && (wait_cnt_q != 8'hFF))
         wait_cnt_d = wait_cnt_q + 8'd1;
      else
         wait_cnt_d = wait_cnt_q;
   end

   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      imm_src     = 3'b000;
      result_src  = 3'b000;
      mem_timeout = 1'b0;
      state_dbg   = 4'd0;
      if (!reset) begin
         state_dbg   = state_q;
         mem_timeout = abort;
         case (state_q)
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               if (opcode == 7'h63)      imm_src = 3'b010;
               else if (opcode == 7'h6F) imm_src = 3'b011;
            end
            S_MEMADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               imm_src   = (opcode == 7'h23) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
               mem_req = !abort;
               adr_src = 1'b1;
            end
            S_MEMWRITE: begin
               mem_req   = !abort;
               mem_write = !abort;
               adr_src   = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               result_src = 3'b001;
            end
            S_EXECR: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXECI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = 2'b10;
            end
            S_ALUWB:  reg_write = 1'b1;
            S_JAL: begin
               pc_write  = 1'b1;
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            S_BEQ: begin
               pc_write  = zero ^ funct3[0];
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               imm_src   = 3'b010;
            end
            S_JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_LUI: begin
               reg_write  = 1'b1;
               imm_src    = 3'b100;
               result_src = 3'b011;
            end
            S_AUIPC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
               imm_src   = 3'b100;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: ;
`endif
            // FETCH, and any unreachable encoding, decode as FETCH
            default: begin
               mem_req    = !abort;
               ir_write   = mem_ready && !abort;
               pc_write   = mem_ready && !abort;
               alu_src_b  = 2'b10;
               result_src = 3'b010;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
// Build with ILLEGAL_TRAP_EN defined to exercise the TRAP expectations.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset, mem_ready, zero, funct7_5;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, mem_timeout;
   logic [1:0] alu_src_a, alu_src_b, alu_op;
   logic [2:0] imm_src, result_src;
   logic [3:0] state_dbg;
   logic [22:0] obs;

   int checks = 0;
   int errors = 0;
   logic [22:0] exp_q[$];

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
      .result_src(result_src), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
   );

   // {state, req wr adr irw pcw rgw, srcA, srcB, aluop, imm, result, timeout}
   assign obs = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, alu_op, imm_src, result_src, mem_timeout};

   localparam logic [22:0] E_RESET     = 23'd0;
   localparam logic [22:0] E_FETCH_RDY = {4'd0,  6'b100110, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 1'b0};
   localparam logic [22:0] E_FETCH_W   = {4'd0,  6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 1'b0};
   localparam logic [22:0] E_FETCH_TO  = {4'd0,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b010, 1'b1};
   localparam logic [22:0] E_DEC_I     = {4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_DEC_B     = {4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 1'b0};
   localparam logic [22:0] E_DEC_J     = {4'd1,  6'b000000, 2'b01, 2'b01, 2'b00, 3'b011, 3'b000, 1'b0};
   localparam logic [22:0] E_MEMADR_I  = {4'd2,  6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_MEMADR_S  = {4'd2,  6'b000000, 2'b10, 2'b01, 2'b00, 3'b001, 3'b000, 1'b0};
   localparam logic [22:0] E_MEMREAD   = {4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_MEMWB     = {4'd4,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 1'b0};
   localparam logic [22:0] E_MEMWRITE  = {4'd5,  6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_MEMWR_TO  = {4'd5,  6'b001000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1};
   localparam logic [22:0] E_EXECR     = {4'd6,  6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_ALUWB     = {4'd7,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_EXECI     = {4'd8,  6'b000000, 2'b10, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_JAL       = {4'd9,  6'b000010, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_BEQ_T     = {4'd10, 6'b000010, 2'b10, 2'b00, 2'b01, 3'b010, 3'b000, 1'b0};
   localparam logic [22:0] E_BEQ_NT    = {4'd10, 6'b000000, 2'b10, 2'b00, 2'b01, 3'b010, 3'b000, 1'b0};
   localparam logic [22:0] E_JALR      = {4'd11, 6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000, 1'b0};
   localparam logic [22:0] E_LUI       = {4'd12, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b100, 3'b011, 1'b0};
   localparam logic [22:0] E_AUIPC     = {4'd13, 6'b000000, 2'b01, 2'b01, 2'b00, 3'b100, 3'b000, 1'b0};
   localparam logic [22:0] E_TRAP      = {4'd14, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0};

   task automatic cyc(input logic rst, input logic rdy, input logic [22:0] expv, input string tag);
      logic [22:0] e;
      reset     = rst;
      mem_ready = rdy;
      exp_q.push_back(expv);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; funct7_5 = 1'b0;
      opcode = 7'h00; funct3 = 3'b000;
      @(posedge clk);
      #1;
      cyc(1, 1, E_RESET, "reset0");
      cyc(1, 1, E_RESET, "reset1");

      opcode = 7'h33;
      cyc(0, 1, E_FETCH_RDY, "add_fetch");
      cyc(0, 1, E_DEC_I,     "add_decode");
      cyc(0, 1, E_EXECR,     "add_execr");
      cyc(0, 1, E_ALUWB,     "add_aluwb");

      opcode = 7'h03;
      cyc(0, 1, E_FETCH_RDY, "lw_fetch");
      cyc(0, 1, E_DEC_I,     "lw_decode");
      cyc(0, 1, E_MEMADR_I,  "lw_memadr");
      for (int i = 0; i < 3; i++) cyc(0, 0, E_MEMREAD, "lw_stall");
      cyc(0, 1, E_MEMREAD,   "lw_ready");
      cyc(0, 1, E_MEMWB,     "lw_memwb");

      opcode = 7'h63; funct3 = 3'b000; zero = 1'b1;
      cyc(0, 1, E_FETCH_RDY, "beq_fetch");
      cyc(0, 1, E_DEC_B,     "beq_decode");
      cyc(0, 1, E_BEQ_T,     "beq_taken");
      funct3 = 3'b001;
      cyc(0, 1, E_FETCH_RDY, "bne_fetch");
      cyc(0, 1, E_DEC_B,     "bne_decode");
      cyc(0, 1, E_BEQ_NT,    "bne_not_taken");
      zero = 1'b0;
      cyc(0, 1, E_FETCH_RDY, "bne2_fetch");
      cyc(0, 1, E_DEC_B,     "bne2_decode");
      cyc(0, 1, E_BEQ_T,     "bne_taken");
      funct3 = 3'b000;

      opcode = 7'h23;
      cyc(0, 1, E_FETCH_RDY, "sw_fetch");
      cyc(0, 1, E_DEC_I,     "sw_decode");
      cyc(0, 1, E_MEMADR_S,  "sw_memadr");
      for (int i = 0; i < 4; i++) cyc(0, 0, E_MEMWRITE, "sw_wait");
      cyc(0, 0, E_MEMWR_TO,  "sw_timeout");
      for (int i = 0; i < 4; i++) cyc(0, 0, E_FETCH_W, "fetch_wait");
      cyc(0, 0, E_FETCH_TO,  "fetch_timeout");
      for (int i = 0; i < 4; i++) cyc(0, 0, E_FETCH_W, "fetch_restart");
      cyc(0, 1, E_FETCH_TO,  "fetch_timeout2");

      opcode = 7'h6F;
      cyc(0, 1, E_FETCH_RDY, "jal_fetch");
      cyc(0, 1, E_DEC_J,     "jal_decode");
      cyc(0, 1, E_JAL,       "jal_jal");
      cyc(0, 1, E_ALUWB,     "jal_link");

      opcode = 7'h67;
      cyc(0, 1, E_FETCH_RDY, "jalr_fetch");
      cyc(0, 1, E_DEC_I,     "jalr_decode");
      cyc(0, 1, E_JALR,      "jalr_jalr");
      cyc(0, 1, E_JAL,       "jalr_jal");
      cyc(0, 1, E_ALUWB,     "jalr_link");

      opcode = 7'h37;
      cyc(0, 1, E_FETCH_RDY, "lui_fetch");
      cyc(0, 1, E_DEC_I,     "lui_decode");
      cyc(0, 1, E_LUI,       "lui_lui");

      opcode = 7'h17;
      cyc(0, 1, E_FETCH_RDY, "auipc_fetch");
      cyc(0, 1, E_DEC_I,     "auipc_decode");
      cyc(0, 1, E_AUIPC,     "auipc_auipc");
      cyc(0, 1, E_ALUWB,     "auipc_wb");

      opcode = 7'h13;
      cyc(0, 1, E_FETCH_RDY, "addi_fetch");
      cyc(0, 1, E_DEC_I,     "addi_decode");
      cyc(0, 1, E_EXECI,     "addi_execi");
      cyc(0, 1, E_ALUWB,     "addi_wb");

      opcode = 7'h23;
      cyc(0, 1, E_FETCH_RDY, "sw2_fetch");
      cyc(0, 1, E_DEC_I,     "sw2_decode");
      cyc(0, 1, E_MEMADR_S,  "sw2_memadr");
      cyc(1, 1, E_RESET,     "reset_mid_store");

      opcode = 7'h7F;
      cyc(0, 1, E_FETCH_RDY, "ill_fetch");
      cyc(0, 1, E_DEC_I,     "ill_decode");
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) cyc(0, 1, E_TRAP, "ill_trap_hold");
      cyc(1, 1, E_RESET,     "trap_reset");
      cyc(0, 1, E_FETCH_RDY, "trap_exit_fetch");
`else
      cyc(0, 1, E_FETCH_RDY, "ill_nop_fetch");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
